// File: rtl/mem_port.sv
// mem_port: data-memory access stage.
// Takes the RAM address held in AR and runs byte reads and writes to data RAM
// over a req/ack handshake. The block is selected on the internal bus by
// MEM_CODE, and it stalls the core through busy while a RAM transaction is
// pending. Writes are posted, so only a following memory access waits on them.
module mem_port #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [3:0]  MEM_CODE   = 4'h5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            addr_bus,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] data_bus_out,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_DONE
  } state_t;

  state_t                state, state_nxt;
  logic                  req_nxt, we_nxt, err_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [DATA_WIDTH-1:0] rd_buf, rd_buf_nxt;
  logic                  dst_hit, src_hit;

  assign dst_hit = (addr_bus[3:0] == MEM_CODE);
  assign src_hit = (addr_bus[7:4] == MEM_CODE);

  // State and registered RAM-side outputs; reset overrides any pending transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_buf    <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      rd_buf    <= rd_buf_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state, next registered values and the combinational stall.
  always_comb begin
    state_nxt  = state;
    req_nxt    = mem_req;
    we_nxt     = mem_we;
    addr_nxt   = mem_addr;
    wdata_nxt  = mem_wdata;
    rd_buf_nxt = rd_buf;
    err_nxt    = err;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        if (src_hit) begin
          // A read takes priority; a simultaneous write request is dropped and flagged.
          addr_nxt  = ram_addr;
          we_nxt    = 1'b0;
          req_nxt   = 1'b1;
          state_nxt = RD_REQ;
          busy      = 1'b1;
          if (dst_hit) begin
            err_nxt = 1'b1;
          end
        end else if (dst_hit) begin
          addr_nxt  = ram_addr;
          wdata_nxt = data_bus_in;
          we_nxt    = 1'b1;
          req_nxt   = 1'b1;
          state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        busy = src_hit | dst_hit;
        if (mem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      RD_REQ: begin
        busy = 1'b1;
        if (mem_ack) begin
          rd_buf_nxt = mem_rdata;
          req_nxt    = 1'b0;
          state_nxt  = RD_DONE;
        end
      end
      RD_DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign data_bus_out = (state == RD_DONE && src_hit) ? rd_buf : '0;

endmodule
